// File: rtl/edu_sched_pkg.sv
// Shared types and constants for the edu datapath sharing scheduler.
package edu_sched_pkg;

  localparam int unsigned TXN_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RETURN
  } sched_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request after index `last`.
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         gnt_onehot,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);

  localparam int unsigned IW = $clog2(N);

  int unsigned w_idx;

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    w_idx      = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_idx = (32'(last) + k) % N;
      if (!any && req[w_idx]) begin
        any               = 1'b1;
        gnt_idx           = IW'(w_idx);
        gnt_onehot[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/edu_share_sched.sv
// Shares one edu datapath among N valid/ready requesters, one transaction
// in flight at a time, round-robin arbitration between transactions.
module edu_share_sched
  import edu_sched_pkg::*;
#(
  parameter int unsigned N = 4,
  parameter int unsigned W = 7
) (
  input  logic                 CLK,
  input  logic                 _RESET,
  input  logic [N-1:0]         req_valid,
  input  logic [N*W-1:0]       req_data,
  output logic [N-1:0]         req_ready,
  output logic                 dp_in_valid,
  output logic [W-1:0]         dp_in_data,
  input  logic                 dp_in_ready,
  input  logic                 dp_out_valid,
  input  logic [W-1:0]         dp_out_data,
  output logic                 dp_out_ready,
  output logic [N-1:0]         rsp_valid,
  output logic [W-1:0]         rsp_data,
  input  logic [N-1:0]         rsp_ready,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 err_spurious,
  output logic [TXN_W-1:0]     txn_count
);

  localparam int unsigned IW = $clog2(N);

  sched_state_t   r_state, w_next;
  logic [W-1:0]   r_op, r_res, w_sel_data;
  logic [IW-1:0]  r_gid, r_last, w_gnt_idx;
  logic [N-1:0]   w_gnt_oh;
  logic           w_any, r_err;
  logic [TXN_W-1:0] r_txn_count;

  rr_pick #(.N(N)) u_pick (
    .req        (req_valid),
    .last       (r_last),
    .gnt_onehot (w_gnt_oh),
    .gnt_idx    (w_gnt_idx),
    .any        (w_any)
  );

  always_comb begin
    w_sel_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (w_gnt_idx == IW'(i)) w_sel_data = req_data[i*W +: W];
    end
  end

  always_comb begin
    w_next       = r_state;
    req_ready    = '0;
    dp_in_valid  = 1'b0;
    dp_out_ready = 1'b0;
    rsp_valid    = '0;
    unique case (r_state)
      IDLE: begin
        // Gated by reset so the accept strobe is low while reset is held.
        if (w_any) begin
          req_ready = w_gnt_oh & {N{_RESET}};
          w_next    = ISSUE;
        end
      end
      ISSUE: begin
        dp_in_valid = 1'b1;
        if (dp_in_ready) w_next = WAIT;
      end
      WAIT: begin
        dp_out_ready = 1'b1;
        if (dp_out_valid) w_next = RETURN;
      end
      RETURN: begin
        rsp_valid[r_gid] = 1'b1;
        if (rsp_ready[r_gid]) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      r_state     <= IDLE;
      r_op        <= '0;
      r_res       <= '0;
      r_gid       <= '0;
      r_last      <= IW'(N - 1);
      r_err       <= 1'b0;
      r_txn_count <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) begin
        r_op  <= w_sel_data;
        r_gid <= w_gnt_idx;
      end
      if (r_state == WAIT && dp_out_valid) r_res <= dp_out_data;
      if (r_state == RETURN && rsp_ready[r_gid]) begin
        r_last      <= r_gid;
        r_txn_count <= r_txn_count + TXN_W'(1);
      end
      if (dp_out_valid && r_state != WAIT) r_err <= 1'b1;
    end
  end

  assign dp_in_data   = r_op;
  assign rsp_data     = r_res;
  assign grant_id     = r_gid;
  assign busy         = (r_state != IDLE);
  assign err_spurious = r_err;
  assign txn_count    = r_txn_count;

endmodule
